// File: rtl/uart_pkt_pkg.sv
// rtl/uart_pkt_pkg.sv - state encoding, default SOF and state-class helpers for uart_pkt_rx
package uart_pkt_pkg;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_DRAIN
    } state_t;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    // States in which bytes are pulled from the UART; DRAIN leaves them queued there
    function automatic logic pops_allowed(input state_t s);
        return s != ST_DRAIN;
    endfunction

    // States between SOF and CHK, where a stalled sender is noticed
    function automatic logic mid_frame(input state_t s);
        return (s == ST_LEN) || (s == ST_PAYLOAD) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/uart_pkt_rx_if.sv
// rtl/uart_pkt_rx_if.sv - UART pop handshake and payload stream bundle for uart_pkt_rx
interface uart_pkt_rx_if;
    logic       rx_empty;
    logic [7:0] r_data;
    logic       rd_uart;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;

    // Receiver side: pops the UART, drives the payload stream
    modport master (
        input  rx_empty, r_data, m_ready,
        output rd_uart, m_valid, m_data, m_last
    );

    // Environment side: UART buffer plus downstream consumer
    modport slave (
        output rx_empty, r_data, m_ready,
        input  rd_uart, m_valid, m_data, m_last
    );
endinterface

// File: rtl/uart_pkt_buf.sv
// rtl/uart_pkt_buf.sv - payload register file, synchronous write and asynchronous read
module uart_pkt_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [DEPTH];

    // Store one payload byte per pop
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Addresses past DEPTH only occur on the look-ahead after the last byte; return 0 there
    assign rdata = (int'(raddr) < DEPTH) ? mem[raddr] : 8'd0;
endmodule

// File: rtl/uart_pkt_rx.sv
// rtl/uart_pkt_rx.sv - framed packet receiver with checksum gate; inter-byte timeout under UART_PKT_TIMEOUT_EN
module uart_pkt_rx
    import uart_pkt_pkg::*;
#(
    parameter int         MAX_LEN       = 16,
    parameter logic [7:0] SOF           = SOF_DEFAULT,
    parameter int         TIMEOUT_TICKS = 160
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_tick,
    uart_pkt_rx_if.master bus,
    output logic          err_chk,
    output logic          err_len,
    output logic          err_to,
    output logic [15:0]   frame_cnt
);
    localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t        state;
    logic [7:0]    len;
    logic [7:0]    sum;
    logic [7:0]    idx;
    logic          armed;
    logic          rd_prev;
    logic          pop;
    logic          we;
    logic [AW-1:0] raddr;
    logic [7:0]    rd_byte;

    // The UART empty flag clears a cycle late, so never pop on two consecutive cycles.
    // armed keeps rd_uart low while reset is held and for the first cycle after it.
    assign pop         = armed && !rd_prev && !bus.rx_empty && pops_allowed(state);
    assign bus.rd_uart = pop;
    assign we          = pop && (state == ST_PAYLOAD);
    // Look one byte ahead so m_data can be registered; CHK preloads byte 0
    assign raddr       = (state == ST_DRAIN) ? idx[AW-1:0] + AW'(1) : '0;

    uart_pkt_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .we    (we),
        .waddr (idx[AW-1:0]),
        .wdata (bus.r_data),
        .raddr (raddr),
        .rdata (rd_byte)
    );

`ifdef UART_PKT_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_TICKS - 1);
    logic [15:0] to_cnt;
`else
    logic unused_tick;
    localparam int unused_to_ticks = TIMEOUT_TICKS;
    assign unused_tick = s_tick;
    assign err_to      = 1'b0;
`endif

    // Frame FSM: hunt, length check, payload capture, checksum verdict, gated drain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_HUNT;
            len         <= 8'd0;
            sum         <= 8'd0;
            idx         <= 8'd0;
            armed       <= 1'b0;
            rd_prev     <= 1'b0;
            bus.m_valid <= 1'b0;
            bus.m_data  <= 8'd0;
            bus.m_last  <= 1'b0;
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
            frame_cnt   <= 16'd0;
`ifdef UART_PKT_TIMEOUT_EN
            err_to      <= 1'b0;
            to_cnt      <= 16'd0;
`endif
        end else begin
            armed   <= 1'b1;
            rd_prev <= pop;
            err_chk <= 1'b0;
            err_len <= 1'b0;
            case (state)
                ST_HUNT: begin
                    if (pop && bus.r_data == SOF) begin
                        state <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (pop) begin
                        if (bus.r_data == 8'd0 || bus.r_data > MAX_LEN_B) begin
                            err_len <= 1'b1;
                            state   <= ST_HUNT;
                        end else begin
                            len   <= bus.r_data;
                            sum   <= bus.r_data;
                            idx   <= 8'd0;
                            state <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (pop) begin
                        sum <= sum + bus.r_data;
                        if (idx == len - 8'd1) begin
                            state <= ST_CHK;
                        end else begin
                            idx <= idx + 8'd1;
                        end
                    end
                end
                ST_CHK: begin
                    if (pop) begin
                        if (sum + bus.r_data == 8'd0) begin
                            state       <= ST_DRAIN;
                            idx         <= 8'd0;
                            bus.m_valid <= 1'b1;
                            bus.m_data  <= rd_byte;
                            bus.m_last  <= (len == 8'd1);
                            frame_cnt   <= frame_cnt + 16'd1;
                        end else begin
                            err_chk <= 1'b1;
                            state   <= ST_HUNT;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (bus.m_valid && bus.m_ready) begin
                        if (bus.m_last) begin
                            bus.m_valid <= 1'b0;
                            bus.m_data  <= 8'd0;
                            bus.m_last  <= 1'b0;
                            state       <= ST_HUNT;
                        end else begin
                            idx        <= idx + 8'd1;
                            bus.m_data <= rd_byte;
                            bus.m_last <= (idx + 8'd1 == len - 8'd1);
                        end
                    end
                end
                default: state <= ST_HUNT;
            endcase
`ifdef UART_PKT_TIMEOUT_EN
            // A pop on the terminal tick wins: the byte is handled above and the count restarts
            err_to <= 1'b0;
            if (pop || !mid_frame(state)) begin
                to_cnt <= 16'd0;
            end else if (s_tick) begin
                if (to_cnt == TO_LAST) begin
                    to_cnt <= 16'd0;
                    err_to <= 1'b1;
                    state  <= ST_HUNT;
                end else begin
                    to_cnt <= to_cnt + 16'd1;
                end
            end
`endif
        end
    end
endmodule

// File: doc/uart_pkt_rx.md
# uart_pkt_rx

Framed-packet receiver sitting directly downstream of the UART receive buffer. Pops bytes via the `rx_empty`/`rd_uart`/`r_data` handshake, hunts for a start-of-frame byte, and collects a length-prefixed payload into an internal buffer. It verifies an 8-bit additive checksum and only then releases the payload as a byte stream with valid/ready flow control. Malformed frames are dropped and flagged.

## Interface
- `MAX_LEN`, 16: largest accepted payload length (1..255).
- `SOF`, 8'hA5: start-of-frame byte value.
- `TIMEOUT_TICKS`, 160: inter-byte timeout in `s_tick` pulses (used only with the timeout macro).

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `s_tick`  in  1  baud oversample tick shared with the UART.
- `rx_empty`  in  1  UART receive buffer empty.
- `r_data`  in  8  UART receive byte; valid while `rx_empty`=0.
- `rd_uart`  out  1  one-cycle pop strobe to the UART.
- `m_valid`  out  1  payload byte available.
- `m_ready`  in  1  downstream accepts byte.
- `m_data`  out  8  payload byte.
- `m_last`  out  1  final payload byte of the frame.
- `err_chk`  out  1  one-cycle pulse: checksum mismatch.
- `err_len`  out  1  one-cycle pulse: LEN = 0 or LEN > MAX_LEN.
- `err_to`  out  1  one-cycle pulse: inter-byte timeout.
- `frame_cnt`  out  16  count of good frames, wraps at 2^16.

## Operation
- Frame format: SOF, LEN, LEN payload bytes, CHK. Good iff (LEN + payload + CHK) mod 256 = 0.
- States:
  - HUNT: non-SOF bytes are popped and discarded; SOF → LEN.
  - LEN: valid length → PAYLOAD and clear sum/index. Invalid length pulses `err_len` → HUNT; the byte is consumed, not re-examined as SOF.
  - PAYLOAD: write byte to buffer[idx], idx++; idx = LEN−1 → CHK.
  - CHK: sum zero → DRAIN and `frame_cnt`++. Sum nonzero pulses `err_chk` → HUNT.
  - DRAIN: present buffer[0..LEN−1]. `m_last`=1 on index LEN−1. Handshake on last byte → HUNT.
- Pop rule: `rd_uart`=1 only in HUNT/LEN/PAYLOAD/CHK, when `rx_empty`=0 and `rd_uart` was 0 the previous cycle. This guarantees one pop per byte despite the UART flag's one-cycle clear latency. `r_data` is captured in the `rd_uart` cycle.
- In DRAIN no pops occur; incoming bytes wait in the UART buffer. UART overrun is not this block's concern.
- Running sum is 8-bit wrapping and covers LEN, payload and CHK.

## Timing
- Reset values: `rd_uart`=0, `m_valid`=0, `m_data`=0, `m_last`=0, all `err_*`=0, `frame_cnt`=0, state HUNT, sum/idx/timeout counter 0.
- Byte popped in cycle N; the state change and any error pulse are registered and visible in cycle N+1.
- After the CHK pop in cycle N, `m_valid`=1 with buffer[0] from cycle N+1.
- `m_data`/`m_last` hold stable while `m_valid`=1 and `m_ready`=0. The next byte is presented the cycle after a handshake.
- After the last handshake, HUNT is entered next cycle; the earliest next pop is the cycle after that.
- Reset mid-frame or mid-drain: immediate abort to reset values; buffer contents don't care.

## Configuration
- `UART_PKT_TIMEOUT_EN` defined:
  - A counter increments on `s_tick` while in LEN/PAYLOAD/CHK and clears on every pop and on entering HUNT.
  - When it reaches `TIMEOUT_TICKS`, `err_to` pulses and the state → HUNT.
  - A pop in the same cycle as terminal count wins: the byte is processed and the counter clears.
- Undefined: no counter; `err_to` tied to 0; `s_tick` unused.

## Structure
- Package `uart_pkt_pkg`: state encoding (HUNT, LEN, PAYLOAD, CHK, DRAIN) and the default SOF constant.
- Sub-module `uart_pkt_buf`: MAX_LEN × 8 register file with one synchronous write port and one asynchronous read port, indexed by `idx`.

## Test plan
- Good frame: A5 03 11 22 33 97 → `m_data` 11, 22, 33 with `m_last` on 33; `frame_cnt`=1; no error pulses.
- Bad checksum: A5 03 11 22 33 98 → `err_chk` one cycle after the 98 pop; `m_valid` never 1; `frame_cnt` unchanged.
- Length errors: A5 00, then A5 11 (17 > 16) → two `err_len` pulses. A following good frame A5 01 5A A5 is delivered (`m_data`=5A, `m_last`=1).
- Garbage and backpressure: 00 FF A5 02 01 02 FB with `rx_empty`=0 throughout.
  - Garbage bytes 00, FF are discarded.
  - Hold `m_ready`=0 for 5 cycles in DRAIN → `m_data`=01 stable and `rd_uart`=0 throughout.
- Pop spacing: `rx_empty` held 0 for 6 cycles → `rd_uart` never high on consecutive cycles.
- Timeout (macro on): A5 02 11, then 160 `s_tick` pulses with no byte → `err_to` pulse, state HUNT. A following good frame is accepted.
